// File: rtl/channel_initial_select_if.sv
//------------------------------------------------------------------------------
// channel_initial_select_if
// Host request/report signals plus the B-side outbound and inbound tags/bus
// of the channel frontend, bundled for the initial selection sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface channel_initial_select_if;
  // host side
  logic       online;
  logic       start;
  logic [7:0] dev_addr;
  logic [7:0] command;
  logic       busy;
  logic       done;
  logic [2:0] result;
  logic [7:0] status;
  // outbound bus and tags
  logic [7:0] bus_out;
  logic       bus_out_parity;
  logic       operational_out;
  logic       address_out;
  logic       select_out;
  logic       hold_out;
  logic       command_out;
  logic       service_out;
  // inbound bus and tags (already synchronized)
  logic [7:0] bus_in;
  logic       bus_in_parity;
  logic       operational_in;
  logic       address_in;
  logic       select_in;
  logic       status_in;

  // sequencer view
  modport slave (
    input  online, start, dev_addr, command,
    input  bus_in, bus_in_parity, operational_in, address_in, select_in, status_in,
    output busy, done, result, status,
    output bus_out, bus_out_parity, operational_out, address_out, select_out,
    output hold_out, command_out, service_out
  );

  // host / frontend view
  modport master (
    output online, start, dev_addr, command,
    output bus_in, bus_in_parity, operational_in, address_in, select_in, status_in,
    input  busy, done, result, status,
    input  bus_out, bus_out_parity, operational_out, address_out, select_out,
    input  hold_out, command_out, service_out
  );
endinterface

`default_nettype wire

// File: rtl/channel_initial_select.sv
//------------------------------------------------------------------------------
// channel_initial_select
// Channel-side sequencer for the initial selection: presents the device
// address, raises select/hold, sends the command byte, acknowledges the
// initial status byte and reports ok/error to the host.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module channel_initial_select #(
  parameter int ADDR_SETUP = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  channel_initial_select_if.slave   ch
);

  typedef enum logic [2:0] {
    IDLE, ADDR, SEL, WAIT_ADDR, CMD, WAIT_STATUS, SVC, DONE
  } state_t;

  localparam logic [15:0] SETUP_LAST   = 16'(ADDR_SETUP - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  localparam logic [2:0] RES_OK       = 3'd0;
  localparam logic [2:0] RES_NODEV    = 3'd1;
  localparam logic [2:0] RES_MISMATCH = 3'd2;
  localparam logic [2:0] RES_TIMEOUT  = 3'd3;
  localparam logic [2:0] RES_PARITY   = 3'd4;

  state_t      state;
  logic [15:0] cnt;
  logic [7:0]  addr_q;
  logic [7:0]  cmd_q;

  logic        in_par_ok;
  logic        timed_out;
  logic        abort;
  logic [2:0]  abort_code;

  assign in_par_ok = (ch.bus_in_parity == ~^ch.bus_in);
  assign timed_out = (cnt == TIMEOUT_LAST);

  // Decide whether this clock ends the sequence with an error, and which one.
  // Losing the host outranks anything the device reports.
  always_comb begin
    abort      = 1'b0;
    abort_code = RES_OK;
    if (state != IDLE && !ch.online) begin
      abort      = 1'b1;
      abort_code = RES_TIMEOUT;
    end else begin
      case (state)
        WAIT_ADDR: begin
          if (ch.operational_in && ch.address_in) begin
            if (ch.bus_in != addr_q) begin
              abort      = 1'b1;
              abort_code = RES_MISMATCH;
            end else if (!in_par_ok) begin
              abort      = 1'b1;
              abort_code = RES_PARITY;
            end
          end else if (ch.select_in) begin
            abort      = 1'b1;
            abort_code = RES_NODEV;
          end else if (timed_out) begin
            abort      = 1'b1;
            abort_code = RES_TIMEOUT;
          end
        end
        CMD: begin
          if (ch.address_in && timed_out) begin
            abort      = 1'b1;
            abort_code = RES_TIMEOUT;
          end
        end
        WAIT_STATUS: begin
          if (ch.status_in && !in_par_ok) begin
            abort      = 1'b1;
            abort_code = RES_PARITY;
          end else if (!ch.status_in && timed_out) begin
            abort      = 1'b1;
            abort_code = RES_TIMEOUT;
          end
        end
        SVC: begin
          if (ch.status_in && timed_out) begin
            abort      = 1'b1;
            abort_code = RES_TIMEOUT;
          end
        end
        DONE: begin
          if (ch.operational_in && timed_out) begin
            abort      = 1'b1;
            abort_code = RES_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  // Selection sequencer: state, wait counter and every registered output.
  // The outbound parity bit is always loaded together with bus_out so it is
  // odd parity of the bus in every cycle (1 while the bus is 0x00).
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= 16'd0;
      addr_q             <= 8'd0;
      cmd_q              <= 8'd0;
      ch.busy            <= 1'b0;
      ch.done            <= 1'b0;
      ch.result          <= 3'd0;
      ch.status          <= 8'd0;
      ch.bus_out         <= 8'd0;
      ch.bus_out_parity  <= 1'b1;
      ch.operational_out <= 1'b0;
      ch.address_out     <= 1'b0;
      ch.select_out      <= 1'b0;
      ch.hold_out        <= 1'b0;
      ch.command_out     <= 1'b0;
      ch.service_out     <= 1'b0;
    end else begin
      ch.operational_out <= ch.online;
      ch.done            <= 1'b0;
      if (abort) begin
        state             <= IDLE;
        cnt               <= 16'd0;
        ch.address_out    <= 1'b0;
        ch.select_out     <= 1'b0;
        ch.hold_out       <= 1'b0;
        ch.command_out    <= 1'b0;
        ch.service_out    <= 1'b0;
        ch.bus_out        <= 8'd0;
        ch.bus_out_parity <= 1'b1;
        ch.done           <= 1'b1;
        ch.result         <= abort_code;
        ch.busy           <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // a start coinciding with the done pulse is not a new request
            if (ch.start && ch.online && !ch.done) begin
              addr_q            <= ch.dev_addr;
              cmd_q             <= ch.command;
              ch.bus_out        <= ch.dev_addr;
              ch.bus_out_parity <= ~^ch.dev_addr;
              ch.address_out    <= 1'b1;
              ch.busy           <= 1'b1;
              cnt               <= 16'd0;
              state             <= ADDR;
            end
          end
          ADDR: begin
            if (cnt == SETUP_LAST) begin
              ch.select_out <= 1'b1;
              ch.hold_out   <= 1'b1;
              cnt           <= 16'd0;
              state         <= SEL;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          SEL: begin
            cnt   <= 16'd0;
            state <= WAIT_ADDR;
          end
          WAIT_ADDR: begin
            if (ch.operational_in && ch.address_in) begin
              ch.address_out    <= 1'b0;
              ch.bus_out        <= cmd_q;
              ch.bus_out_parity <= ~^cmd_q;
              ch.command_out    <= 1'b1;
              cnt               <= 16'd0;
              state             <= CMD;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          CMD: begin
            if (!ch.address_in) begin
              ch.command_out <= 1'b0;
              cnt            <= 16'd0;
              state          <= WAIT_STATUS;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          WAIT_STATUS: begin
            if (ch.status_in) begin
              ch.status      <= ch.bus_in;
              ch.service_out <= 1'b1;
              cnt            <= 16'd0;
              state          <= SVC;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          SVC: begin
            if (!ch.status_in) begin
              ch.service_out    <= 1'b0;
              ch.select_out     <= 1'b0;
              ch.hold_out       <= 1'b0;
              ch.bus_out        <= 8'd0;
              ch.bus_out_parity <= 1'b1;
              cnt               <= 16'd0;
              state             <= DONE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          DONE: begin
            if (!ch.operational_in) begin
              ch.done   <= 1'b1;
              ch.result <= RES_OK;
              ch.busy   <= 1'b0;
              cnt       <= 16'd0;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_channel_initial_select.sv
//------------------------------------------------------------------------------
// tb_channel_initial_select
// Directed bench: stimulus tasks act as host and device, pushing the expected
// done response into a queue; a monitor pops and compares on every done.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_channel_initial_select;

  localparam int M_NORMAL  = 0;
  localparam int M_NODEV   = 1;
  localparam int M_TIMEOUT = 2;
  localparam int M_OFFLINE = 3;
  localparam int M_RESET   = 4;
  localparam int M_IGNORE  = 5;

  localparam int S_ADDR = 0;
  localparam int S_SEL  = 1;
  localparam int S_CMD  = 2;
  localparam int S_SVC  = 3;
  localparam int S_BUSY = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  channel_initial_select_if ch();

  channel_initial_select #(.ADDR_SETUP(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .ch    (ch)
  );

  typedef struct {
    logic [2:0] res;
    logic [7:0] st;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      S_ADDR:  sig = ch.address_out;
      S_SEL:   sig = ch.select_out;
      S_CMD:   sig = ch.command_out;
      S_SVC:   sig = ch.service_out;
      default: sig = ch.busy;
    endcase
  endfunction

  function automatic logic [15:0] tags();
    tags = {11'd0, ch.address_out, ch.select_out, ch.hold_out, ch.command_out, ch.service_out};
  endfunction

  // bounded wait on an outbound tag; n = negedges waited
  task automatic wait_sig(input int which, input logic val, output int n);
    n = 0;
    while (sig(which) !== val && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL wait_tag_%0d: no change to %0d within 100 clocks", which, val);
    end
  endtask

  task automatic clear_dev();
    ch.bus_in         = 8'd0;
    ch.bus_in_parity  = 1'b1;
    ch.operational_in = 1'b0;
    ch.address_in     = 1'b0;
    ch.select_in      = 1'b0;
    ch.status_in      = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every done pops one expected response.
  always @(negedge clk) begin
    if (ch.done) begin
      chk("done_back_to_back", 16'(prev_done), 16'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %0d required no done", ch.result);
      end else begin
        mon_e = q.pop_front();
        chk("result", 16'(ch.result), 16'(mon_e.res));
        if (mon_e.res == 3'd0) chk("status", 16'(ch.status), 16'(mon_e.st));
      end
    end
    prev_done = ch.done;
  end

  task automatic run(input int mode, input logic [7:0] addr, input logic [7:0] cmd,
                     input logic [7:0] echo, input logic echo_bad,
                     input logic [7:0] st, input logic st_bad, input logic [2:0] er);
    int   n;
    exp_t e;
    logic saw;
    if (mode != M_RESET) begin
      e.res = er;
      e.st  = st;
      q.push_back(e);
    end
    ch.dev_addr = addr;
    ch.command  = cmd;
    ch.start    = 1'b1;
    @(negedge clk);
    ch.start = 1'b0;
    chk("addr_out_on", 16'(ch.address_out), 16'd1);
    chk("bus_is_addr", 16'(ch.bus_out), 16'(addr));
    chk("bus_addr_par", 16'(ch.bus_out_parity), 16'(~^addr));
    chk("busy_on", 16'(ch.busy), 16'd1);
    wait_sig(S_SEL, 1'b1, n);
    chk("setup_clocks", 16'(n), 16'd4);
    chk("hold_with_sel", 16'(ch.hold_out), 16'd1);
    if (mode == M_IGNORE) begin
      ch.dev_addr = 8'h55;
      ch.start    = 1'b1;
      @(negedge clk);
      ch.start = 1'b0;
      @(negedge clk);
      chk("bus_keeps_addr", 16'(ch.bus_out), 16'(addr));
      chk("busy_kept", 16'(ch.busy), 16'd1);
    end
    if (mode == M_NODEV) begin
      ch.select_in = 1'b1;
      wait_sig(S_BUSY, 1'b0, n);
      chk("nodev_latency", 16'(n), 16'd2);
      chk("nodev_tags", tags(), 16'd0);
    end else if (mode == M_TIMEOUT) begin
      wait_sig(S_BUSY, 1'b0, n);
      // select visible in SEL; WAIT_ADDR entered on the next edge
      chk("timeout_clocks", 16'(n), 16'd17);
      chk("timeout_tags", tags(), 16'd0);
    end else begin
      ch.bus_in         = echo;
      ch.bus_in_parity  = (~^echo) ^ echo_bad;
      ch.operational_in = 1'b1;
      ch.address_in     = 1'b1;
      if (er != 3'd0 && !st_bad && mode != M_OFFLINE) begin
        wait_sig(S_BUSY, 1'b0, n);
        chk("addr_err_tags", tags(), 16'd0);
        chk("addr_err_bus", 16'(ch.bus_out), 16'd0);
      end else begin
        wait_sig(S_CMD, 1'b1, n);
        chk("cmd_after_addr_low", 16'(ch.address_out), 16'd0);
        chk("bus_is_cmd", 16'(ch.bus_out), 16'(cmd));
        if (mode == M_OFFLINE) begin
          ch.online = 1'b0;
          wait_sig(S_BUSY, 1'b0, n);
          chk("offline_latency", 16'(n), 16'd1);
          chk("offline_tags", tags(), 16'd0);
          ch.online = 1'b1;
        end else begin
          ch.address_in    = 1'b0;
          wait_sig(S_CMD, 1'b0, n);
          ch.bus_in        = st;
          ch.bus_in_parity = (~^st) ^ st_bad;
          ch.status_in     = 1'b1;
          if (st_bad) begin
            n   = 0;
            saw = 1'b0;
            while (ch.busy && n < 100) begin
              @(negedge clk);
              saw |= ch.service_out;
              n++;
            end
            chk("st_par_done", 16'(ch.busy), 16'd0);
            chk("st_par_no_service", 16'(saw), 16'd0);
            chk("st_par_tags", tags(), 16'd0);
          end else begin
            wait_sig(S_SVC, 1'b1, n);
            chk("sel_during_svc", 16'(ch.select_out), 16'd1);
            if (mode == M_RESET) begin
              reset = 1'b1;
              @(negedge clk);
              chk("rst_tags", tags(), 16'd0);
              chk("rst_busy", 16'(ch.busy), 16'd0);
              chk("rst_bus", 16'(ch.bus_out), 16'd0);
              chk("rst_done", 16'(ch.done), 16'd0);
              reset = 1'b0;
            end else begin
              ch.status_in = 1'b0;
              wait_sig(S_SEL, 1'b0, n);
              chk("svc_end_service", 16'(ch.service_out), 16'd0);
              chk("svc_end_bus", 16'(ch.bus_out), 16'd0);
              chk("svc_end_par", 16'(ch.bus_out_parity), 16'd1);
              ch.operational_in = 1'b0;
              wait_sig(S_BUSY, 1'b0, n);
              if (mode == M_IGNORE) begin
                // start on the clock done is shown must be ignored
                ch.start = 1'b1;
                @(negedge clk);
                ch.start = 1'b0;
                chk("start_with_done_ignored", 16'(ch.busy), 16'd0);
              end
            end
          end
        end
      end
    end
    clear_dev();
  endtask

  initial begin
    reset       = 1'b1;
    ch.online   = 1'b0;
    ch.start    = 1'b0;
    ch.dev_addr = 8'd0;
    ch.command  = 8'd0;
    clear_dev();
    @(negedge clk);
    chk("reset_busy", 16'(ch.busy), 16'd0);
    chk("reset_done", 16'(ch.done), 16'd0);
    chk("reset_result", 16'(ch.result), 16'd0);
    chk("reset_status", 16'(ch.status), 16'd0);
    chk("reset_bus", 16'(ch.bus_out), 16'd0);
    chk("reset_par", 16'(ch.bus_out_parity), 16'd1);
    chk("reset_tags", tags(), 16'd0);
    chk("reset_opout", 16'(ch.operational_out), 16'd0);
    reset = 1'b0;
    // start while offline is ignored
    ch.start = 1'b1;
    @(negedge clk);
    ch.start = 1'b0;
    @(negedge clk);
    chk("offline_start_ignored", 16'(ch.busy), 16'd0);
    ch.online = 1'b1;
    @(negedge clk);
    chk("opout_follows_online", 16'(ch.operational_out), 16'd1);

    run(M_NORMAL,  8'h1A, 8'h02, 8'h1A, 1'b0, 8'h0C, 1'b0, 3'd0);
    run(M_NODEV,   8'h1A, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, 3'd1);
    run(M_NORMAL,  8'h1A, 8'h02, 8'h1B, 1'b0, 8'h00, 1'b0, 3'd2);
    run(M_NORMAL,  8'h1A, 8'h02, 8'h1A, 1'b1, 8'h00, 1'b0, 3'd4);
    run(M_NORMAL,  8'h1A, 8'h02, 8'h1A, 1'b0, 8'h0C, 1'b1, 3'd4);
    run(M_TIMEOUT, 8'h1A, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, 3'd3);
    run(M_OFFLINE, 8'h1A, 8'h02, 8'h1A, 1'b0, 8'h00, 1'b0, 3'd3);
    run(M_RESET,   8'h1A, 8'h02, 8'h1A, 1'b0, 8'h0C, 1'b0, 3'd0);
    run(M_NORMAL,  8'h1A, 8'h02, 8'h1A, 1'b0, 8'h0C, 1'b0, 3'd0);
    run(M_NORMAL,  8'h00, 8'hFF, 8'h00, 1'b0, 8'h80, 1'b0, 3'd0);
    run(M_IGNORE,  8'h1A, 8'h07, 8'h1A, 1'b0, 8'h33, 1'b0, 3'd0);

    repeat (4) @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute guard against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
